// File: rtl/dbb_burst_scheduler.sv
// dbb_burst_scheduler
// Serialises NVDLA DBB AXI read and write bursts onto one axi2mem bridge. Only one burst
// is in flight at a time. Reads and writes are granted round-robin. The block gates
// handshakes only. Address, id, data, strobe and response wires bypass it in the parent.
// It also checks each burst's beat count against last and counts completed bursts.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ar_*/aw_* _valid_i,_len_i      DBB address request      -> ar/aw_ready_o back to DBB
//   ar_*/aw_* _valid_o,_ready_i    axi2mem address channel
//   w_valid_i, w_last_i, w_ready_o DBB write data           <-> w_valid_o, w_ready_i axi2mem
//   r_valid_i, r_last_i, r_ready_o axi2mem read data        <-> r_valid_o, r_ready_i DBB
//   b_valid_i, b_ready_o           axi2mem write response   <-> b_valid_o, b_ready_i DBB
//   busy_o                         a burst is being arbitrated or is in flight
//   len_err_o, clr_err_i           sticky last/beat-count mismatch flag and its clear
//   rd_cnt_o, wr_cnt_o             completed read and write bursts, wrapping
module dbb_burst_scheduler #(
    parameter int unsigned LEN_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter bit          RD_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ar_valid_i,
    input  logic [LEN_WIDTH-1:0] ar_len_i,
    output logic                 ar_ready_o,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    input  logic                 aw_valid_i,
    input  logic [LEN_WIDTH-1:0] aw_len_i,
    output logic                 aw_ready_o,
    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,
    input  logic                 w_valid_i,
    input  logic                 w_last_i,
    output logic                 w_ready_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    input  logic                 r_valid_i,
    input  logic                 r_last_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic                 r_ready_o,
    input  logic                 b_valid_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic                 b_ready_o,
    output logic                 busy_o,
    output logic                 len_err_o,
    input  logic                 clr_err_i,
    output logic [CNT_WIDTH-1:0] rd_cnt_o,
    output logic [CNT_WIDTH-1:0] wr_cnt_o
);

    typedef enum logic [2:0] {StIdle, StAr, StRd, StAw, StWd, StWb} state_e;

    // Beat counter saturates at 2^LEN_WIDTH, one past the largest legal beat index.
    localparam logic [LEN_WIDTH:0] BeatMax = {1'b1, {LEN_WIDTH{1'b0}}};

    state_e                 state_q, state_d;
    logic                   prio_rd_q, prio_rd_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH:0]     beat_q, beat_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                   data_hs, data_last, err_set;

    always_comb begin
        state_d    = state_q;
        prio_rd_d  = prio_rd_q;
        len_d      = len_q;
        beat_d     = beat_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        data_hs    = 1'b0;
        data_last  = 1'b0;
        err_set    = 1'b0;
        ar_valid_o = 1'b0;
        ar_ready_o = 1'b0;
        aw_valid_o = 1'b0;
        aw_ready_o = 1'b0;
        w_valid_o  = 1'b0;
        w_ready_o  = 1'b0;
        r_valid_o  = 1'b0;
        r_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        b_ready_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Grant is decided here; the granted channel opens next cycle.
                if (ar_valid_i && (!aw_valid_i || prio_rd_q)) begin
                    state_d   = StAr;
                    len_d     = ar_len_i;
                    prio_rd_d = 1'b0;
                end else if (aw_valid_i) begin
                    state_d   = StAw;
                    len_d     = aw_len_i;
                    prio_rd_d = 1'b1;
                end
            end
            StAr: begin
                ar_valid_o = ar_valid_i;
                ar_ready_o = ar_ready_i;
                if (ar_valid_i && ar_ready_i) begin
                    state_d = StRd;
                    beat_d  = '0;
                end
            end
            StRd: begin
                r_valid_o = r_valid_i;
                r_ready_o = r_ready_i;
                if (r_valid_i && r_ready_i) begin
                    data_hs   = 1'b1;
                    data_last = r_last_i;
                    if (r_last_i) begin
                        state_d  = StIdle;
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            StAw: begin
                aw_valid_o = aw_valid_i;
                aw_ready_o = aw_ready_i;
                if (aw_valid_i && aw_ready_i) begin
                    state_d = StWd;
                    beat_d  = '0;
                end
            end
            StWd: begin
                w_valid_o = w_valid_i;
                w_ready_o = w_ready_i;
                if (w_valid_i && w_ready_i) begin
                    data_hs   = 1'b1;
                    data_last = w_last_i;
                    if (w_last_i) state_d = StWb;
                end
            end
            StWb: begin
                b_valid_o = b_valid_i;
                b_ready_o = b_ready_i;
                if (b_valid_i && b_ready_i) begin
                    state_d  = StIdle;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Error when last arrives early/late or is missing on the final beat; the burst is
        // neither cut short nor stretched, it simply follows last.
        if (data_hs) begin
            if (beat_q != BeatMax) beat_d = beat_q + 1'b1;
            if (data_last != (beat_q == {1'b0, len_q})) err_set = 1'b1;
        end

        err_d = err_set ? 1'b1 : (clr_err_i ? 1'b0 : err_q);

        // Keep every gate shut while reset is held, not just from the following cycle.
        if (rst) begin
            ar_valid_o = 1'b0;
            ar_ready_o = 1'b0;
            aw_valid_o = 1'b0;
            aw_ready_o = 1'b0;
            w_valid_o  = 1'b0;
            w_ready_o  = 1'b0;
            r_valid_o  = 1'b0;
            r_ready_o  = 1'b0;
            b_valid_o  = 1'b0;
            b_ready_o  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            prio_rd_q <= RD_FIRST;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign len_err_o = err_q;
    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;

endmodule

// File: tb/tb_dbb_burst_scheduler.sv
// Directed bench for dbb_burst_scheduler plus a randomised back-to-back burst run with a
// small DBB/axi2mem model and completed-burst scoreboard.
module tb_dbb_burst_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
    logic [3:0]  ar_len_i, aw_len_i;
    logic        aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
    logic        w_valid_i, w_last_i, w_ready_o, w_valid_o, w_ready_i;
    logic        r_valid_i, r_last_i, r_valid_o, r_ready_i, r_ready_o;
    logic        b_valid_i, b_valid_o, b_ready_i, b_ready_o;
    logic        busy_o, len_err_o, clr_err_i;
    logic [15:0] rd_cnt_o, wr_cnt_o;
    logic [9:0]  gates;

    int n_tests = 0;
    int n_fail  = 0;

    // Random-run model state
    localparam int NB     = 300;
    localparam int BUDGET = 40000;
    int          started, rd_done, wr_done, cyc, rd_beat, wr_beat;
    logic        rd_req, rd_data, wr_req, wr_data, wr_resp;
    logic [3:0]  rlen, wlen;
    logic        rd_side, wr_side;

    always #5 clk = ~clk;

    assign gates = {ar_valid_o, ar_ready_o, aw_valid_o, aw_ready_o, w_valid_o, w_ready_o,
                    r_valid_o, r_ready_o, b_valid_o, b_ready_o};

    dbb_burst_scheduler #(
        .LEN_WIDTH (4),
        .CNT_WIDTH (16),
        .RD_FIRST  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ar_valid_i (ar_valid_i),
        .ar_len_i   (ar_len_i),
        .ar_ready_o (ar_ready_o),
        .ar_valid_o (ar_valid_o),
        .ar_ready_i (ar_ready_i),
        .aw_valid_i (aw_valid_i),
        .aw_len_i   (aw_len_i),
        .aw_ready_o (aw_ready_o),
        .aw_valid_o (aw_valid_o),
        .aw_ready_i (aw_ready_i),
        .w_valid_i  (w_valid_i),
        .w_last_i   (w_last_i),
        .w_ready_o  (w_ready_o),
        .w_valid_o  (w_valid_o),
        .w_ready_i  (w_ready_i),
        .r_valid_i  (r_valid_i),
        .r_last_i   (r_last_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_ready_o  (r_ready_o),
        .b_valid_i  (b_valid_i),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .b_ready_o  (b_ready_o),
        .busy_o     (busy_o),
        .len_err_o  (len_err_o),
        .clr_err_i  (clr_err_i),
        .rd_cnt_o   (rd_cnt_o),
        .wr_cnt_o   (wr_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ar_valid_i = 1'b0; ar_len_i = '0; ar_ready_i = 1'b0;
        aw_valid_i = 1'b0; aw_len_i = '0; aw_ready_i = 1'b0;
        w_valid_i  = 1'b0; w_last_i = 1'b0; w_ready_i = 1'b0;
        r_valid_i  = 1'b0; r_last_i = 1'b0; r_ready_i = 1'b0;
        b_valid_i  = 1'b0; b_ready_i = 1'b0;
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        clr_err_i = 1'b0;
        step();
        step();

        // Reset: gates shut even with inputs pushing, everything cleared
        ar_valid_i = 1'b1; ar_ready_i = 1'b1; r_valid_i = 1'b1; r_ready_i = 1'b1;
        #1;
        chk("rst_gates", 32'(gates), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(len_err_o), 0);
        chk("rst_rd_cnt", 32'(rd_cnt_o), 0);
        chk("rst_wr_cnt", 32'(wr_cnt_o), 0);
        idle_in();
        rst = 1'b0;
        step();

        // Single read, len 3, four beats
        ar_valid_i = 1'b1; ar_len_i = 4'd3;
        #1;
        chk("t1_idle_gate", 32'(ar_valid_o), 0);
        chk("t1_idle_busy", 32'(busy_o), 0);
        step();
        chk("t1_ar_valid", 32'(ar_valid_o), 1);
        chk("t1_ar_busy", 32'(busy_o), 1);
        ar_ready_i = 1'b1;
        #1;
        chk("t1_ar_ready", 32'(ar_ready_o), 1);
        step();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_last_i = (i == 3);
            #1;
            chk("t1_r_pass", 32'({r_valid_o, r_ready_o}), 3);
            step();
        end
        r_valid_i = 1'b0; r_last_i = 1'b0; r_ready_i = 1'b0;
        #1;
        chk("t1_rd_cnt", 32'(rd_cnt_o), 1);
        chk("t1_busy_low", 32'(busy_o), 0);
        chk("t1_err", 32'(len_err_o), 0);

        // Simultaneous requests after reset: read first, then write wins the next pair
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t2_rd_cnt_clr", 32'(rd_cnt_o), 0);
        ar_valid_i = 1'b1; aw_valid_i = 1'b1; ar_len_i = '0; aw_len_i = '0;
        step();
        chk("t2_first_ar", 32'({ar_valid_o, aw_valid_o}), 2);
        ar_ready_i = 1'b1;
        step();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_last_i = 1'b1; r_ready_i = 1'b1;
        #1;
        chk("t2_aw_blocked", 32'({aw_valid_o, aw_ready_o}), 0);
        step();
        r_valid_i = 1'b0; r_last_i = 1'b0; r_ready_i = 1'b0;
        ar_valid_i = 1'b1;
        #1;
        chk("t2_idle_gap", 32'(busy_o), 0);
        step();
        chk("t2_second_aw", 32'({ar_valid_o, aw_valid_o}), 1);
        aw_ready_i = 1'b1;
        step();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
        w_valid_i = 1'b1; w_last_i = 1'b1; w_ready_i = 1'b1;
        #1;
        chk("t2_ar_blocked", 32'(ar_valid_o), 0);
        step();
        w_valid_i = 1'b0; w_last_i = 1'b0; w_ready_i = 1'b0;
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        #1;
        chk("t2_b_pass", 32'({b_valid_o, b_ready_o}), 3);
        step();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        #1;
        chk("t2_wr_cnt", 32'(wr_cnt_o), 1);
        step();
        chk("t2_third_ar", 32'(ar_valid_o), 1);
        ar_ready_i = 1'b1;
        step();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_last_i = 1'b1; r_ready_i = 1'b1;
        step();
        r_valid_i = 1'b0; r_last_i = 1'b0; r_ready_i = 1'b0;
        #1;
        chk("t2_rd_cnt", 32'(rd_cnt_o), 2);
        chk("t2_err", 32'(len_err_o), 0);

        // Write data offered before the address: held until WD
        w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = 1'b0;
        #1;
        chk("t3_w_held_idle", 32'({w_valid_o, w_ready_o}), 0);
        step();
        aw_valid_i = 1'b1; aw_len_i = 4'd1;
        #1;
        chk("t3_w_held_idle2", 32'(w_ready_o), 0);
        step();
        chk("t3_w_held_aw", 32'(w_ready_o), 0);
        aw_ready_i = 1'b1;
        step();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
        #1;
        chk("t3_w_open", 32'(w_ready_o), 1);
        step();
        w_last_i = 1'b1;
        step();
        w_valid_i = 1'b0; w_last_i = 1'b0; w_ready_i = 1'b0;
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        step();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        #1;
        chk("t3_wr_cnt", 32'(wr_cnt_o), 2);
        chk("t3_err", 32'(len_err_o), 0);

        // Read len 3 terminated early on beat 2
        ar_valid_i = 1'b1; ar_len_i = 4'd3; ar_ready_i = 1'b1;
        step();
        step();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b0;
        step();
        r_last_i = 1'b1;
        #1;
        chk("t4_no_err_yet", 32'(len_err_o), 0);
        step();
        r_valid_i = 1'b0; r_last_i = 1'b0; r_ready_i = 1'b0;
        #1;
        chk("t4_err_set", 32'(len_err_o), 1);
        chk("t4_idle", 32'(busy_o), 0);
        chk("t4_rd_cnt", 32'(rd_cnt_o), 3);
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        #1;
        chk("t4_err_clr", 32'(len_err_o), 0);

        // Read len 0 missing last on its only beat; set beats a same-cycle clear
        ar_valid_i = 1'b1; ar_len_i = 4'd0; ar_ready_i = 1'b1;
        step();
        step();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b0; clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        #1;
        chk("t4b_err_overrun", 32'(len_err_o), 1);
        chk("t4b_still_busy", 32'(busy_o), 1);
        r_last_i = 1'b1;
        step();
        r_valid_i = 1'b0; r_last_i = 1'b0; r_ready_i = 1'b0;
        #1;
        chk("t4b_rd_cnt", 32'(rd_cnt_o), 4);
        chk("t4b_idle", 32'(busy_o), 0);
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;

        // Reset during beat 2 of an 8-beat write
        aw_valid_i = 1'b1; aw_len_i = 4'd7; aw_ready_i = 1'b1;
        step();
        step();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
        w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_gates", 32'(gates), 0);
        chk("t5_busy", 32'(busy_o), 0);
        chk("t5_rd_cnt", 32'(rd_cnt_o), 0);
        chk("t5_wr_cnt", 32'(wr_cnt_o), 0);
        chk("t5_err", 32'(len_err_o), 0);
        step();
        chk("t5_gates_idle", 32'(gates), 0);
        idle_in();
        step();

        // Random back-to-back bursts with stalls on both sides
        started = 0; rd_done = 0; wr_done = 0; cyc = 0; rd_beat = 0; wr_beat = 0;
        rd_req = 1'b0; rd_data = 1'b0; wr_req = 1'b0; wr_data = 1'b0; wr_resp = 1'b0;
        rlen = '0; wlen = '0;
        while ((rd_done + wr_done < NB) && (cyc < BUDGET)) begin
            if (!rd_req && !rd_data && started < NB && $urandom_range(0, 2) == 0) begin
                rd_req = 1'b1;
                rlen = 4'($urandom_range(0, 3));
                started++;
            end
            if (!wr_req && !wr_data && !wr_resp && started < NB && $urandom_range(0, 2) == 0) begin
                wr_req = 1'b1;
                wlen = 4'($urandom_range(0, 3));
                started++;
            end
            ar_valid_i = rd_req;  ar_len_i = rlen;  ar_ready_i = 1'($urandom_range(0, 1));
            aw_valid_i = wr_req;  aw_len_i = wlen;  aw_ready_i = 1'($urandom_range(0, 1));
            r_valid_i  = rd_data && ($urandom_range(0, 1) == 1);
            r_last_i   = (rd_beat == int'(rlen));
            r_ready_i  = 1'($urandom_range(0, 1));
            w_valid_i  = (wr_req || wr_data) && ($urandom_range(0, 1) == 1);
            w_last_i   = (wr_beat == int'(wlen));
            w_ready_i  = 1'($urandom_range(0, 1));
            b_valid_i  = wr_resp && ($urandom_range(0, 1) == 1);
            b_ready_i  = 1'($urandom_range(0, 1));
            #1;
            rd_side = ar_valid_o | ar_ready_o | r_valid_o | r_ready_o;
            wr_side = aw_valid_o | aw_ready_o | w_valid_o | w_ready_o | b_valid_o | b_ready_o;
            chk("rand_overlap", 32'(rd_side && wr_side), 0);
            chk("rand_err", 32'(len_err_o), 0);
            if (ar_valid_i && ar_ready_o) begin
                rd_req = 1'b0; rd_data = 1'b1; rd_beat = 0;
            end
            if (r_valid_o && r_ready_i) begin
                if (r_last_i) begin
                    rd_data = 1'b0; rd_done++;
                end else begin
                    rd_beat++;
                end
            end
            if (aw_valid_i && aw_ready_o) begin
                wr_req = 1'b0; wr_data = 1'b1; wr_beat = 0;
            end
            if (w_valid_i && w_ready_o) begin
                if (w_last_i) begin
                    wr_data = 1'b0; wr_resp = 1'b1;
                end else begin
                    wr_beat++;
                end
            end
            if (b_valid_o && b_ready_i) begin
                wr_resp = 1'b0; wr_done++;
            end
            cyc++;
            step();
        end
        idle_in();
        #1;
        chk("rand_all_done", 32'(rd_done + wr_done), NB);
        chk("rand_rd_cnt", 32'(rd_cnt_o), 32'(rd_done));
        chk("rand_wr_cnt", 32'(wr_cnt_o), 32'(wr_done));
        chk("rand_idle", 32'(busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
